sram_arbiter: RTL and testbench
===============================

# sram_arbiter

Shares one single-read/single-write-port `Sram` instance between one write requester (the loader) and two read requesters (A: conv engine, B: fc engine) in the LeNet accelerator. Writes are always granted. Reads are arbitrated round-robin with a bounded burst length. A read that hits the address being written in the same cycle is held off one cycle, so readers always see the newest data. Each read returns its data one cycle after grant, tagged to the requester that issued it.

## Interface
Parameters:
- `DATA_WIDTH`, 8, word width; must match `Sram`.
- `ADDR_WIDTH`, 8, address width; must match `Sram`.
- `MAX_BURST`, 4, maximum consecutive read grants to one reader while the other is waiting; ≥1.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `wr_req`  in  1  write request.
- `wr_req_addr`  in  ADDR_WIDTH  write address.
- `wr_req_data`  in  DATA_WIDTH  write data.
- `wr_gnt`  out  1  write accepted this cycle.
- `rda_req`, `rdb_req`  in  1  read requests.
- `rda_addr`, `rdb_addr`  in  ADDR_WIDTH  read addresses.
- `rda_gnt`, `rdb_gnt`  out  1  read accepted this cycle.
- `rda_valid`, `rdb_valid`  out  1  return-data strobe.
- `rda_data`, `rdb_data`  out  DATA_WIDTH  return data.
- `sram_csen`  out  1  to `Sram` `csen`.
- `sram_wr_en`  out  1  to `Sram` `wr_en`.
- `sram_wr_addr`  out  ADDR_WIDTH  to `Sram` `wr_addr`.
- `sram_wr_data`  out  DATA_WIDTH  to `Sram` `wr_data`.
- `sram_rd_en`  out  1  to `Sram` `rd_en`.
- `sram_rd_addr`  out  ADDR_WIDTH  to `Sram` `rd_addr`.
- `sram_rd_data`  in  DATA_WIDTH  from `Sram` `rd_data`.

## Operation
- **Handshake:**
  - A requester holds `req` and its address/data stable until it sees `gnt`=1.
  - `gnt` is combinational from the current `req`s and state; a transfer occurs in any cycle where `req`&`gnt`.
- **Write path:**
  - `wr_gnt`=`wr_req`.
  - `sram_wr_en`=`wr_req`.
  - `sram_wr_addr`/`sram_wr_data` pass through.
- **Read eligibility:**
  - A reader is eligible if its `req`=1 and NOT (`wr_req`=1 and its addr==`wr_req_addr`).
  - An ineligible reader is not granted that cycle. It is re-evaluated the next cycle and then returns the written value.
- **Arbitration state:**
  - `owner` (A/B): the last reader granted.
  - `burst_cnt` (0..MAX_BURST): consecutive grants to `owner`.
- **Grant rules:**
  - Exactly one reader eligible: grant it.
  - Both eligible: grant `owner` if `burst_cnt`<MAX_BURST, else grant the other reader.
  - No reader eligible: no grant; state unchanged.
- **State update on a grant:**
  - Grant to `owner`: `burst_cnt`←min(`burst_cnt`+1, MAX_BURST).
  - Grant to the non-owner: `owner`←granted reader, `burst_cnt`←1.
- **SRAM read drive:**
  - `sram_rd_en`=`rda_gnt`|`rdb_gnt`.
  - `sram_rd_addr`=granted reader's address; all zeros when idle.
  - `sram_csen`=`sram_wr_en`|`sram_rd_en`.
- **Return path:**
  - Registered tag `rtn_a`, `rtn_b` ← `rda_gnt`, `rdb_gnt`.
  - `rdX_valid`=`rtn_X`.
  - `rdX_data`=`sram_rd_data` when `rtn_X`=1, else all zeros. The `Sram` output is never forwarded unqualified; its reset value is high-Z.
- At most one of `rda_gnt`/`rdb_gnt`, and at most one of `rda_valid`/`rdb_valid`, is high in any cycle.

## Timing
- **Reset** (async assert, sync-to-clk deassert expected):
  - `owner`=A, `burst_cnt`=0, `rtn_a`=`rtn_b`=0.
  - While `rst_n`=0, all `gnt`, `valid`, and `sram_*` enables are forced to 0; all data/address outputs are 0.
  - First tie after reset goes to A.
- **Read latency:**
  - Grant in cycle T; `rdX_valid`=1 with data in cycle T+1.
  - Back-to-back grants give one word per cycle.
- **Write:** the memory updates at the end of the cycle in which it is granted. A read of the same address granted at T+1 or later returns the new data.
- **Reset mid-operation:** an outstanding return tag is cleared; no `valid` is produced for a read granted in the cycle before reset.
- `burst_cnt` saturates at MAX_BURST. The only path back to 1 is a switch to the other reader.

## Test plan
1. **Reset:** hold `rst_n`=0 with all reqs high → every gnt/valid/enable is 0. Release, then both readers request → A is granted first.
2. **Single read:**
   - Write 0x5A to addr 0x10.
   - Next cycle, A reads 0x10 → `rda_gnt` at T, `rda_valid`=1 and `rda_data`=0x5A at T+1, `rdb_valid`=0.
3. **Burst fairness:** A and B request continuously with MAX_BURST=4 → grant pattern A,A,A,A,B,B,B,B,A,…, with one valid per cycle tagged correctly.
4. **Collision:**
   - Same cycle: `wr_req` to 0x20 with data 0xC3, and A reads 0x20 → `rda_gnt`=0 that cycle.
   - If B is eligible that cycle, it is granted instead.
   - Next cycle: A is granted; one cycle later `rda_data`=0xC3.
5. **Lone requester:** B alone requests 10 cycles → granted all 10 cycles, `burst_cnt` saturates at 4. A then joins → A is granted on the next cycle.
6. **Reset mid-read:** grant A at T, assert `rst_n` low before the T+1 edge → `rda_valid` stays 0, and `owner`=A, `burst_cnt`=0 after release.

Source files
------------

// File: rtl/sram_arbiter.sv
// Shares one single-read/single-write SRAM between a loader (writes) and two
// readers arbitrated round-robin with a bounded burst; returns tagged read data.
module sram_arbiter #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned MAX_BURST  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] wr_req_addr,
  input  logic [DATA_WIDTH-1:0] wr_req_data,
  output logic                  wr_gnt,
  input  logic                  rda_req,
  input  logic [ADDR_WIDTH-1:0] rda_addr,
  input  logic                  rdb_req,
  input  logic [ADDR_WIDTH-1:0] rdb_addr,
  output logic                  rda_gnt,
  output logic                  rdb_gnt,
  output logic                  rda_valid,
  output logic                  rdb_valid,
  output logic [DATA_WIDTH-1:0] rda_data,
  output logic [DATA_WIDTH-1:0] rdb_data,
  output logic                  sram_csen,
  output logic                  sram_wr_en,
  output logic [ADDR_WIDTH-1:0] sram_wr_addr,
  output logic [DATA_WIDTH-1:0] sram_wr_data,
  output logic                  sram_rd_en,
  output logic [ADDR_WIDTH-1:0] sram_rd_addr,
  input  logic [DATA_WIDTH-1:0] sram_rd_data
);

  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

  typedef enum logic {
    OWN_A = 1'b0,
    OWN_B = 1'b1
  } owner_e;

  owner_e           owner_q, owner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rtn_a_q, rtn_b_q;
  logic             elig_a, elig_b;
  logic             gnt_a, gnt_b;

  // Arbitration state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q <= OWN_A;
      cnt_q   <= '0;
    end else begin
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end

  // Eligibility, grant selection and burst bookkeeping
  always_comb begin
    owner_d = owner_q;
    cnt_d   = cnt_q;
    gnt_a   = 1'b0;
    gnt_b   = 1'b0;
    // A read colliding with the write this cycle waits so it sees the new word
    elig_a  = rst_n & rda_req & ~(wr_req & (rda_addr == wr_req_addr));
    elig_b  = rst_n & rdb_req & ~(wr_req & (rdb_addr == wr_req_addr));

    if (elig_a && elig_b) begin
      if (cnt_q < MAX_CNT) begin
        gnt_a = (owner_q == OWN_A);
        gnt_b = (owner_q == OWN_B);
      end else begin
        gnt_a = (owner_q == OWN_B);
        gnt_b = (owner_q == OWN_A);
      end
    end else if (elig_a) begin
      gnt_a = 1'b1;
    end else if (elig_b) begin
      gnt_b = 1'b1;
    end

    if ((gnt_a && owner_q == OWN_A) || (gnt_b && owner_q == OWN_B)) begin
      if (cnt_q < MAX_CNT) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (gnt_a) begin
      owner_d = OWN_A;
      cnt_d   = CNT_W'(1);
    end else if (gnt_b) begin
      owner_d = OWN_B;
      cnt_d   = CNT_W'(1);
    end
  end

  // Return tags: one-cycle SRAM read latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rtn_a_q <= 1'b0;
      rtn_b_q <= 1'b0;
    end else begin
      rtn_a_q <= gnt_a;
      rtn_b_q <= gnt_b;
    end
  end

  assign wr_gnt       = rst_n & wr_req;
  assign sram_wr_en   = rst_n & wr_req;
  assign sram_wr_addr = sram_wr_en ? wr_req_addr : '0;
  assign sram_wr_data = sram_wr_en ? wr_req_data : '0;

  assign rda_gnt      = gnt_a;
  assign rdb_gnt      = gnt_b;
  assign sram_rd_en   = gnt_a | gnt_b;
  assign sram_rd_addr = gnt_a ? rda_addr : (gnt_b ? rdb_addr : '0);
  assign sram_csen    = sram_wr_en | sram_rd_en;

  // SRAM output is qualified by the tag so its undriven value never leaks out
  assign rda_valid = rtn_a_q;
  assign rdb_valid = rtn_b_q;
  assign rda_data  = rtn_a_q ? sram_rd_data : '0;
  assign rdb_data  = rtn_b_q ? sram_rd_data : '0;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a behavioural SRAM (1-cycle read latency).
module tb_sram_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_req;
  logic [7:0] wr_req_addr, wr_req_data;
  logic       wr_gnt;
  logic       rda_req, rdb_req;
  logic [7:0] rda_addr, rdb_addr;
  logic       rda_gnt, rdb_gnt, rda_valid, rdb_valid;
  logic [7:0] rda_data, rdb_data;
  logic       sram_csen, sram_wr_en, sram_rd_en;
  logic [7:0] sram_wr_addr, sram_wr_data, sram_rd_addr, sram_rd_data;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sram_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .MAX_BURST(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_req(wr_req), .wr_req_addr(wr_req_addr), .wr_req_data(wr_req_data), .wr_gnt(wr_gnt),
    .rda_req(rda_req), .rda_addr(rda_addr), .rdb_req(rdb_req), .rdb_addr(rdb_addr),
    .rda_gnt(rda_gnt), .rdb_gnt(rdb_gnt), .rda_valid(rda_valid), .rdb_valid(rdb_valid),
    .rda_data(rda_data), .rdb_data(rdb_data),
    .sram_csen(sram_csen), .sram_wr_en(sram_wr_en), .sram_wr_addr(sram_wr_addr),
    .sram_wr_data(sram_wr_data), .sram_rd_en(sram_rd_en), .sram_rd_addr(sram_rd_addr),
    .sram_rd_data(sram_rd_data)
  );

  // Behavioural SRAM: write at end of cycle, registered read data
  logic [7:0] mem [256];
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    sram_rd_data = 8'h00;
  end
  always @(posedge clk) begin
    if (sram_csen && sram_wr_en) mem[sram_wr_addr] <= sram_wr_data;
    if (sram_csen && sram_rd_en) sram_rd_data <= mem[sram_rd_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic       wr;
    logic [7:0] wa, wd;
    logic       ra;
    logic [7:0] aa;
    logic       rb;
    logic [7:0] ab;
    logic       eg_a, eg_b, ev_a, ev_b;
    logic [7:0] ed_a, ed_b;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic wr, logic [7:0] wa, logic [7:0] wd,
                              logic ra, logic [7:0] aa, logic rb, logic [7:0] ab,
                              logic eg_a, logic eg_b, logic ev_a, logic ev_b,
                              logic [7:0] ed_a, logic [7:0] ed_b);
    vec_t v;
    v.wr = wr; v.wa = wa; v.wd = wd; v.ra = ra; v.aa = aa; v.rb = rb; v.ab = ab;
    v.eg_a = eg_a; v.eg_b = eg_b; v.ev_a = ev_a; v.ev_b = ev_b;
    v.ed_a = ed_a; v.ed_b = ed_b;
    return v;
  endfunction

  task automatic drive(input logic wr, input logic [7:0] wa, input logic [7:0] wd,
                       input logic ra, input logic [7:0] aa, input logic rb, input logic [7:0] ab);
    wr_req = wr; wr_req_addr = wa; wr_req_data = wd;
    rda_req = ra; rda_addr = aa; rdb_req = rb; rdb_addr = ab;
  endtask

  // Both readers request continuously: expect A x4 then B (fresh state after reset)
  task automatic check_fresh_burst(input string tag);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive(1'b0, 8'h00, 8'h00, 1'b1, 8'h10, 1'b1, 8'h20);
      #1;
      check({tag, "_gnt_a"}, 32'(rda_gnt), 32'(i < 4));
      check({tag, "_gnt_b"}, 32'(rdb_gnt), 32'(i == 4));
    end
    @(negedge clk);
    drive(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    drive(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b1, 8'h33, 8'hEE, 1'b1, 8'h10, 1'b1, 8'h20);

    // Reset held with every request high
    repeat (3) @(negedge clk);
    #1;
    check("rst_wr_gnt", 32'(wr_gnt), 0);
    check("rst_gnts", 32'({rda_gnt, rdb_gnt}), 0);
    check("rst_valids", 32'({rda_valid, rdb_valid}), 0);
    check("rst_enables", 32'({sram_csen, sram_wr_en, sram_rd_en}), 0);
    check("rst_addr_data", 32'({sram_wr_addr, sram_wr_data, sram_rd_addr}), 0);
    check("rst_rd_data", 32'({rda_data, rdb_data}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00);
    check_fresh_burst("post_rst");
    pulse_reset();

    // Table: single read, collision, burst alternation, lone requester
    vecs.push_back(mk(1, 8'h10, 8'h5A, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00));
    vecs.push_back(mk(0, 8'h00, 8'h00, 1, 8'h10, 0, 8'h00, 1, 0, 0, 0, 8'h00, 8'h00));
    vecs.push_back(mk(0, 8'h00, 8'h00, 0, 8'h00, 0, 8'h00, 0, 0, 1, 0, 8'h5A, 8'h00));
    vecs.push_back(mk(1, 8'h20, 8'hC3, 1, 8'h20, 1, 8'h10, 0, 1, 0, 0, 8'h00, 8'h00));
    vecs.push_back(mk(0, 8'h00, 8'h00, 1, 8'h20, 0, 8'h00, 1, 0, 0, 1, 8'h00, 8'h5A));
    vecs.push_back(mk(0, 8'h00, 8'h00, 0, 8'h00, 0, 8'h00, 0, 0, 1, 0, 8'hC3, 8'h00));
    // owner A, burst 1: A three more, then B four, then A
    vecs.push_back(mk(0, 8'h00, 8'h00, 1, 8'h10, 1, 8'h20, 1, 0, 0, 0, 8'h00, 8'h00));
    vecs.push_back(mk(0, 8'h00, 8'h00, 1, 8'h10, 1, 8'h20, 1, 0, 1, 0, 8'h5A, 8'h00));
    vecs.push_back(mk(0, 8'h00, 8'h00, 1, 8'h10, 1, 8'h20, 1, 0, 1, 0, 8'h5A, 8'h00));
    vecs.push_back(mk(0, 8'h00, 8'h00, 1, 8'h10, 1, 8'h20, 0, 1, 1, 0, 8'h5A, 8'h00));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(0, 8'h00, 8'h00, 1, 8'h10, 1, 8'h20, 0, 1, 0, 1, 8'h00, 8'hC3));
    vecs.push_back(mk(0, 8'h00, 8'h00, 1, 8'h10, 1, 8'h20, 1, 0, 0, 1, 8'h00, 8'hC3));
    vecs.push_back(mk(0, 8'h00, 8'h00, 1, 8'h10, 1, 8'h20, 1, 0, 1, 0, 8'h5A, 8'h00));
    // B alone ten cycles saturates its burst; A joining is granted at once
    vecs.push_back(mk(0, 8'h00, 8'h00, 0, 8'h00, 1, 8'h20, 0, 1, 1, 0, 8'h5A, 8'h00));
    for (int i = 0; i < 9; i++)
      vecs.push_back(mk(0, 8'h00, 8'h00, 0, 8'h00, 1, 8'h20, 0, 1, 0, 1, 8'h00, 8'hC3));
    vecs.push_back(mk(0, 8'h00, 8'h00, 1, 8'h10, 1, 8'h20, 1, 0, 0, 1, 8'h00, 8'hC3));
    vecs.push_back(mk(0, 8'h00, 8'h00, 0, 8'h00, 0, 8'h00, 0, 0, 1, 0, 8'h5A, 8'h00));

    foreach (vecs[i]) begin
      vec_t v;
      logic [7:0] exp_rd_addr;
      v = vecs[i];
      exp_rd_addr = v.eg_a ? v.aa : (v.eg_b ? v.ab : 8'h00);
      @(negedge clk);
      drive(v.wr, v.wa, v.wd, v.ra, v.aa, v.rb, v.ab);
      #1;
      check($sformatf("v%0d_wr_gnt", i), 32'(wr_gnt), 32'(v.wr));
      check($sformatf("v%0d_gnt_a", i), 32'(rda_gnt), 32'(v.eg_a));
      check($sformatf("v%0d_gnt_b", i), 32'(rdb_gnt), 32'(v.eg_b));
      check($sformatf("v%0d_valid_a", i), 32'(rda_valid), 32'(v.ev_a));
      check($sformatf("v%0d_valid_b", i), 32'(rdb_valid), 32'(v.ev_b));
      check($sformatf("v%0d_data_a", i), 32'(rda_data), 32'(v.ed_a));
      check($sformatf("v%0d_data_b", i), 32'(rdb_data), 32'(v.ed_b));
      check($sformatf("v%0d_csen", i), 32'(sram_csen), 32'(v.wr | v.eg_a | v.eg_b));
      check($sformatf("v%0d_rd_addr", i), 32'(sram_rd_addr), 32'(exp_rd_addr));
    end

    // Reset between grant and return: tag must be dropped
    @(negedge clk);
    drive(1'b0, 8'h00, 8'h00, 1'b1, 8'h10, 1'b0, 8'h00);
    #1;
    check("mid_rst_gnt_a", 32'(rda_gnt), 1);
    #2;
    rst_n = 1'b0;
    drive(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1;
      check("mid_rst_valid_a", 32'(rda_valid), 0);
      check("mid_rst_data_a", 32'(rda_data), 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("mid_rst_valid_after", 32'(rda_valid), 0);
    check_fresh_burst("mid_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
